// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the unified memory port between the MIPS core and the loader.
// Define MEM_ARB_STATS_EN to add saturating per-master grant counters.
module mem_arbiter #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [1:0]       cpu_we,
  input  logic             cpu_dword,
  input  logic [N-1:0]     cpu_addr,
  input  logic [N-1:0]     cpu_wdata,
  output logic [N-1:0]     cpu_rdata,
  output logic             cpu_ready,
  input  logic             dbg_req,
  input  logic [1:0]       dbg_we,
  input  logic             dbg_dword,
  input  logic [N-1:0]     dbg_addr,
  input  logic [N-1:0]     dbg_wdata,
  output logic [N-1:0]     dbg_rdata,
  output logic             dbg_ready,
  output logic [1:0]       mem_we,
  output logic             mem_dword,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic [N-1:0]     mem_rdata,
  output logic [1:0]       owner
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] cpu_grants,
  output logic [CNT_W-1:0] dbg_grants
`endif
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGntCpu = 2'b01,
    StGntDbg = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_dbg_q, last_dbg_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      last_dbg_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
    end
  end

  // Contention goes to whichever master did not win the previous grant.
  always_comb begin
    state_d    = StIdle;
    last_dbg_d = last_dbg_q;
    if (cpu_req && dbg_req) begin
      state_d = last_dbg_q ? StGntCpu : StGntDbg;
    end else if (cpu_req) begin
      state_d = StGntCpu;
    end else if (dbg_req) begin
      state_d = StGntDbg;
    end
    if (state_d == StGntCpu) begin
      last_dbg_d = 1'b0;
    end else if (state_d == StGntDbg) begin
      last_dbg_d = 1'b1;
    end
  end

  // A master that withdraws its request in its grant cycle gets no write and no ready.
  always_comb begin
    mem_we    = 2'b00;
    mem_dword = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    dbg_ready = 1'b0;
    dbg_rdata = '0;
    unique case (state_q)
      StGntCpu: begin
        mem_we    = cpu_req ? cpu_we : 2'b00;
        mem_dword = cpu_dword;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = cpu_req;
        cpu_rdata = mem_rdata;
      end
      StGntDbg: begin
        mem_we    = dbg_req ? dbg_we : 2'b00;
        mem_dword = dbg_dword;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        dbg_ready = dbg_req;
        dbg_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign owner = state_q;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] cpu_grants_q, dbg_grants_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_grants_q <= '0;
      dbg_grants_q <= '0;
    end else begin
      if (cpu_ready && (cpu_grants_q != '1)) cpu_grants_q <= cpu_grants_q + 1'b1;
      if (dbg_ready && (dbg_grants_q != '1)) dbg_grants_q <= dbg_grants_q + 1'b1;
    end
  end

  assign cpu_grants = cpu_grants_q;
  assign dbg_grants = dbg_grants_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Grant-counter checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_dword, dbg_req, dbg_dword;
  logic [1:0]  cpu_we, dbg_we, mem_we, owner;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic        cpu_ready, dbg_ready, mem_dword;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_grants, dbg_grants;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.N(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_dword(cpu_dword), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_dword(dbg_dword), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_we(mem_we), .mem_dword(mem_dword), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
`ifdef MEM_ARB_STATS_EN
    , .cpu_grants(cpu_grants), .dbg_grants(dbg_grants)
`endif
  );

  // Memory behind the arbiter: combinational read, write on any nonzero memwrite code.
  logic        mem_init = 1'b0;
  logic [63:0] mem [64];

  function automatic logic [63:0] init_val(input int i);
    return (i == 2) ? 64'h1234 : {32'hC0DE0000, 32'(i)};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_we != 2'b00) begin
      mem[mem_addr[8:3]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[8:3]];

  // Reference model state
  logic [63:0] ref_mem [64];
  logic [1:0]  m_owner;
  logic        m_last_dbg;
  int          m_cg, m_dg;
  logic        m_cpu_done, m_dbg_done;
  logic [63:0] obs_crdata;
  logic        obs_cready;
  logic [1:0]  obs_mem_we;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = 2'd0;
    m_last_dbg = 1'b1;
    m_cg       = 0;
    m_dg       = 0;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_dword = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_dword = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset    = 1'b1;
    mem_init = 1'b1;
    #1;
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_dbg_ready", 64'(dbg_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    model_reset();
  endtask

  // One cycle: drive at edge+1, check before the next edge, advance the model at the edge.
  task automatic step(input logic cr, input logic [1:0] cw, input logic cd,
                      input logic [63:0] ca, input logic [63:0] cwd,
                      input logic dr, input logic [1:0] dw, input logic dd,
                      input logic [63:0] da, input logic [63:0] dwd);
    logic [1:0]  e_we;
    logic        e_dw, e_cr, e_dr;
    logic [63:0] e_addr, e_wdata, e_crd, e_drd;
    cpu_req = cr; cpu_we = cw; cpu_dword = cd; cpu_addr = ca; cpu_wdata = cwd;
    dbg_req = dr; dbg_we = dw; dbg_dword = dd; dbg_addr = da; dbg_wdata = dwd;
    #3;
    e_we = 2'b00; e_dw = 1'b0; e_cr = 1'b0; e_dr = 1'b0;
    e_addr = 64'd0; e_wdata = 64'd0; e_crd = 64'd0; e_drd = 64'd0;
    if (m_owner == 2'd1) begin
      e_we = cr ? cw : 2'b00; e_dw = cd; e_addr = ca; e_wdata = cwd; e_cr = cr;
      e_crd = ref_mem[ca[8:3]];
    end else if (m_owner == 2'd2) begin
      e_we = dr ? dw : 2'b00; e_dw = dd; e_addr = da; e_wdata = dwd; e_dr = dr;
      e_drd = ref_mem[da[8:3]];
    end
    check("owner", 64'(owner), 64'(m_owner));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_dword", 64'(mem_dword), 64'(e_dw));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("cpu_ready", 64'(cpu_ready), 64'(e_cr));
    check("dbg_ready", 64'(dbg_ready), 64'(e_dr));
    check("cpu_rdata", cpu_rdata, e_crd);
    check("dbg_rdata", dbg_rdata, e_drd);
`ifdef MEM_ARB_STATS_EN
    check("cpu_grants", 64'(cpu_grants), 64'(m_cg));
    check("dbg_grants", 64'(dbg_grants), 64'(m_dg));
`endif
    obs_crdata = cpu_rdata;
    obs_cready = cpu_ready;
    obs_mem_we = mem_we;
    @(posedge clk);
    m_cpu_done = (m_owner == 2'd1) && cr;
    m_dbg_done = (m_owner == 2'd2) && dr;
    if (m_cpu_done) begin
      if (cw != 2'b00) ref_mem[ca[8:3]] = cwd;
      if (m_cg < 65535) m_cg++;
    end
    if (m_dbg_done) begin
      if (dw != 2'b00) ref_mem[da[8:3]] = dwd;
      if (m_dg < 65535) m_dg++;
    end
    if (cr && dr) m_owner = m_last_dbg ? 2'd1 : 2'd2;
    else if (cr)  m_owner = 2'd1;
    else if (dr)  m_owner = 2'd2;
    else          m_owner = 2'd0;
    if (m_owner != 2'd0) m_last_dbg = (m_owner == 2'd2);
    #1;
  endtask

  task automatic idle();
    step(0, 2'b00, 0, 64'd0, 64'd0, 0, 2'b00, 0, 64'd0, 64'd0);
  endtask

  logic [1:0]  exp_own [4];
  logic        c_pend, d_pend;
  logic [1:0]  c_we_r, d_we_r;
  logic        c_dw_r, d_dw_r;
  logic [63:0] c_ad_r, d_ad_r, c_wd_r, d_wd_r;

  initial begin
    reset = 1'b0;
    clear_inputs();
    do_reset();

    // Reset asserted in the middle of a CPU write grant.
    step(1, 2'b01, 1, 64'h20, 64'hBAD0BAD0, 0, 2'b00, 0, 64'd0, 64'd0);
    #2;
    check("t1_pre_we", 64'(mem_we), 64'd1);
    reset = 1'b1;
    #1;
    check("t1_we", 64'(mem_we), 64'd0);
    check("t1_owner", 64'(owner), 64'd0);
    check("t1_ready", 64'(cpu_ready), 64'd0);
    check("t1_rdata", cpu_rdata, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    check("t1_mem", mem[4], init_val(4));

    // Single CPU read of a preloaded word.
    idle();
    step(1, 2'b00, 1, 64'h10, 64'd0, 0, 2'b00, 0, 64'd0, 64'd0);
    step(1, 2'b00, 1, 64'h10, 64'd0, 0, 2'b00, 0, 64'd0, 64'd0);
    check("t2_ready", 64'(obs_cready), 64'd1);
    check("t2_rdata", obs_crdata, 64'h1234);
    idle();

    // Both masters requesting from reset alternate strictly, CPU first.
    do_reset();
    exp_own[0] = 2'd1; exp_own[1] = 2'd2; exp_own[2] = 2'd1; exp_own[3] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      step(1, 2'b00, 1, 64'h08, 64'd0, 1, 2'b00, 1, 64'h18, 64'd0);
      check("t3_owner", 64'(owner), 64'(exp_own[k]));
    end
    idle();
    idle();

    // Loader writes, core reads the same word back.
    step(0, 2'b00, 0, 64'd0, 64'd0, 1, 2'b01, 1, 64'h40, 64'hDEAD);
    step(0, 2'b00, 0, 64'd0, 64'd0, 1, 2'b01, 1, 64'h40, 64'hDEAD);
    step(1, 2'b00, 1, 64'h40, 64'd0, 0, 2'b00, 0, 64'd0, 64'd0);
    step(1, 2'b00, 1, 64'h40, 64'd0, 0, 2'b00, 0, 64'd0, 64'd0);
    check("t4_rdata", obs_crdata, 64'hDEAD);
    idle();

    // Core withdraws its write request in its grant cycle.
    step(1, 2'b01, 1, 64'h48, 64'hFACE, 0, 2'b00, 0, 64'd0, 64'd0);
    step(0, 2'b01, 1, 64'h48, 64'hFACE, 0, 2'b00, 0, 64'd0, 64'd0);
    check("t5_we", 64'(obs_mem_we), 64'd0);
    check("t5_ready", 64'(obs_cready), 64'd0);
    check("t5_mem", mem[9], init_val(9));
    idle();

`ifdef MEM_ARB_STATS_EN
    // Five core accesses then three loader accesses, then counters cleared by reset.
    do_reset();
    for (int k = 0; k < 6; k++) step(1, 2'b00, 1, 64'h10, 64'd0, 0, 2'b00, 0, 64'd0, 64'd0);
    idle();
    for (int k = 0; k < 4; k++) step(0, 2'b00, 0, 64'd0, 64'd0, 1, 2'b00, 1, 64'h20, 64'd0);
    idle();
    check("t6_cpu_grants", 64'(cpu_grants), 64'd5);
    check("t6_dbg_grants", 64'(dbg_grants), 64'd3);
    reset = 1'b1;
    #1;
    check("t6_cpu_clr", 64'(cpu_grants), 64'd0);
    check("t6_dbg_clr", 64'(dbg_grants), 64'd0);
    #1;
    reset = 1'b0;
`endif

    // Random traffic; masters hold a request until served, occasionally abandoning it.
    do_reset();
    c_pend = 0; d_pend = 0;
    c_we_r = 0; d_we_r = 0; c_dw_r = 0; d_dw_r = 0;
    c_ad_r = 0; d_ad_r = 0; c_wd_r = 0; d_wd_r = 0;
    for (int n = 0; n < 400; n++) begin
      if (!c_pend && ($urandom_range(0, 9) < 7)) begin
        c_pend = 1; c_we_r = 2'($urandom_range(0, 3)); c_dw_r = 1'($urandom_range(0, 1));
        c_ad_r = 64'($urandom_range(0, 63)) << 3; c_wd_r = {$urandom, $urandom};
      end else if (c_pend && ($urandom_range(0, 19) == 0)) begin
        c_pend = 0;
      end
      if (!d_pend && ($urandom_range(0, 9) < 6)) begin
        d_pend = 1; d_we_r = 2'($urandom_range(0, 3)); d_dw_r = 1'($urandom_range(0, 1));
        d_ad_r = 64'($urandom_range(0, 63)) << 3; d_wd_r = {$urandom, $urandom};
      end else if (d_pend && ($urandom_range(0, 19) == 0)) begin
        d_pend = 0;
      end
      step(c_pend, c_we_r, c_dw_r, c_ad_r, c_wd_r, d_pend, d_we_r, d_dw_r, d_ad_r, d_wd_r);
      if (m_cpu_done) c_pend = 0;
      if (m_dbg_done) d_pend = 0;
    end
    idle();
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
